// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter in front of a cpu_to_axi adapter's CPU-side memory port.
// Latches the winning request, returns a one-cycle ready pulse and waits out the adapter release.
module cpu_mem_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_instr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_instr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        rr_next;
  logic [15:0] tmo_cnt;
  logic        pick;

  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid)
      pick = (PRIORITY_MODE == 1) ? 1'b0 : rr_next;
    else if (req1_valid)
      pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_next     <= 1'b0;
      tmo_cnt     <= '0;
      req0_ready  <= 1'b0;
      req0_rdata  <= '0;
      req1_ready  <= 1'b0;
      req1_rdata  <= '0;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            mem_valid <= 1'b1;
            mem_instr <= pick ? req1_instr : req0_instr;
            mem_addr  <= pick ? req1_addr  : req0_addr;
            mem_wdata <= pick ? req1_wdata : req0_wdata;
            mem_wstrb <= pick ? req1_wstrb : req0_wstrb;
            grant_id  <= pick;
            rr_next   <= ~pick;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (grant_id) begin
              req1_rdata <= mem_rdata;
              req1_ready <= 1'b1;
            end else begin
              req0_rdata <= mem_rdata;
              req0_ready <= 1'b1;
            end
            state <= RELEASE;
          end else if (tmo_cnt != TMO_LIMIT) begin
            // The adapter cannot be cancelled, so a timeout only flags and keeps waiting.
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt + 16'd1 == TMO_LIMIT)
              err_timeout <= 1'b1;
          end
        end
        RELEASE: begin
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          if (!mem_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a small adapter responder model
// (configurable ready latency and release hold time).
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_instr = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_wstrb = '0;
  logic        req0_ready;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_instr = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_wstrb = '0;
  logic        req1_ready;
  logic [31:0] req1_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, grant_id, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  cpu_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Adapter model: mem_ready rises lat edges after mem_valid, stays high hold extra edges after mem_valid drops.
  int          lat = 3;
  int          hold = 0;
  int          acnt = 0;
  int          hcnt = 0;
  logic [31:0] rdata_val = 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      acnt      <= 0;
      hcnt      <= 0;
    end else if (mem_valid && !mem_ready) begin
      if (acnt + 1 >= lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= rdata_val;
        acnt      <= 0;
      end else begin
        acnt <= acnt + 1;
      end
    end else if (!mem_valid && mem_ready) begin
      if (hcnt >= hold) begin
        mem_ready <= 1'b0;
        hcnt      <= 0;
      end else begin
        hcnt <= hcnt + 1;
      end
    end
  end

  int   cyc = 0;
  int   r0_pulses = 0;
  int   r1_pulses = 0;
  int   last_ready_cyc = 0;
  logic prev_mv = 1'b0;
  logic prev_rdy = 1'b0;
  logic grants[$];
  int   gaps[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req0_ready) r0_pulses++;
    if (req1_ready) r1_pulses++;
    if ((req0_ready || req1_ready) && !prev_rdy) last_ready_cyc = cyc;
    if (mem_valid && !prev_mv) begin
      grants.push_back(grant_id);
      gaps.push_back(cyc - last_ready_cyc);
    end
    prev_mv  = mem_valid;
    prev_rdy = req0_ready || req1_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int n = 0;
    while (!(req0_ready || req1_ready) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, 32'(req0_ready | req1_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   fcyc;
    logic ok;

    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_grant_err", 32'({grant_id, err_timeout}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read on req0
    req0_addr = 32'h0000_000C; req0_wstrb = 4'h0; req0_valid = 1'b1;
    @(negedge clk);
    check("rd0_mem_valid", 32'(mem_valid), 32'd1);
    check("rd0_mem_addr", mem_addr, 32'h0000_000C);
    check("rd0_grant", 32'(grant_id), 32'd0);
    check("rd0_busy", 32'(busy), 32'd1);
    wait_ready("rd0", 20);
    check("rd0_req0_ready", 32'(req0_ready), 32'd1);
    check("rd0_rdata", req0_rdata, 32'hDEAD_BEEF);
    check("rd0_mem_valid_drop", 32'(mem_valid), 32'd0);
    req0_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rd0_pulses0", 32'(r0_pulses), 32'd1);
    check("rd0_pulses1", 32'(r1_pulses), 32'd0);
    check("rd0_rdata_hold", req0_rdata, 32'hDEAD_BEEF);
    check("rd0_idle_busy", 32'(busy), 32'd0);

    // Write on req1
    rdata_val = 32'h1111_1111;
    req1_addr = 32'h40; req1_wdata = 32'h1234_5678; req1_wstrb = 4'hF; req1_valid = 1'b1;
    @(negedge clk);
    check("wr1_grant", 32'(grant_id), 32'd1);
    ok = 1'b1;
    n  = 0;
    while (!req1_ready && n < 20) begin
      if (!mem_valid || mem_wstrb !== 4'hF || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h40)
        ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("wr1_stable", 32'(ok), 32'd1);
    check("wr1_req1_ready", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0; req1_wstrb = 4'h0;
    repeat (5) @(negedge clk);
    check("wr1_pulses1", 32'(r1_pulses), 32'd1);
    check("wr1_pulses0", 32'(r0_pulses), 32'd1);

    // Contention, round-robin
    grants.delete(); gaps.delete();
    rdata_val = 32'h2222_2222;
    req0_addr = 32'h100; req1_addr = 32'h200;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready("rr", 40);
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("rr_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      check($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(i % 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), 32'(gaps[i] >= 3), 32'd1);
    end

    // Release handshake with long mem_ready hold
    hold = 5; rdata_val = 32'h0BAD_F00D;
    req0_addr = 32'h300; req0_valid = 1'b1;
    @(negedge clk);
    check("rel_mem_valid", 32'(mem_valid), 32'd1);
    wait_ready("rel", 20);
    check("rel_rdata", req0_rdata, 32'h0BAD_F00D);
    ok = 1'b1;
    n  = 0;
    while (mem_ready && n < 20) begin
      if (!busy || mem_valid) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("rel_mr_fall", 32'(mem_ready), 32'd0);
    if (!busy) ok = 1'b0;
    check("rel_busy_held", 32'(ok), 32'd1);
    fcyc = cyc;
    hold = 0;
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rel_next_valid", 32'(mem_valid), 32'd1);
    check("rel_gap", 32'(cyc - fcyc >= 2), 32'd1);
    wait_ready("rel2", 20);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Timeout (TIMEOUT_CYCLES = 8)
    lat = 30; rdata_val = 32'hA5A5_5A5A;
    req1_addr = 32'h500; req1_valid = 1'b1;
    @(negedge clk);
    check("to_mem_valid", 32'(mem_valid), 32'd1);
    check("to_err_start", 32'(err_timeout), 32'd0);
    repeat (7) @(negedge clk);
    check("to_err_7", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    check("to_err_9", 32'(err_timeout), 32'd1);
    wait_ready("to", 40);
    check("to_req1_ready", 32'(req1_ready), 32'd1);
    check("to_rdata", req1_rdata, 32'hA5A5_5A5A);
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("to_err_sticky", 32'(err_timeout), 32'd1);
    check("to_idle", 32'(busy), 32'd0);

    // Reset mid-ISSUE; rr_next is 1 here after a lone req0 grant
    req0_addr = 32'h600; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_mem_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rm_mem_valid0", 32'(mem_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rm_rdata0", req0_rdata, 32'd0);
    check("rm_rdata1", req1_rdata, 32'd0);
    check("rm_err", 32'(err_timeout), 32'd0);
    check("rm_mem_addr", mem_addr, 32'd0);
    rst = 1'b0; lat = 3;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rm_rr_reset_grant", 32'(grant_id), 32'd0);
    check("rm_new_valid", 32'(mem_valid), 32'd1);
    wait_ready("rm", 20);
    check("rm_req0_ready", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
